// File: rtl/gb_video_pkg.sv
// rtl/gb_video_pkg.sv - shared PPU mode enum, memory map and DMA constants
package gb_video_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } PPU_STATES_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_ISSUE = 2'd1,
    DMA_DRAIN = 2'd2
  } dma_state_t;

  localparam logic [15:0] TILE_BASE     = 16'h8000;
  localparam logic [15:0] VRAM_END_ADDR = 16'h9FFF;
  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
  localparam logic [15:0] OAM_END_ADDR  = 16'hFE9F;
  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam int          DMA_LEN       = 160;

endpackage

// File: rtl/gb_oam_dma.sv
// rtl/gb_oam_dma.sv - OAM DMA engine: issue FSM, byte index and one-deep write pipeline
module gb_oam_dma #(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_hi,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        active
);
  import gb_video_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state, state_nx;
  logic [7:0] base_hi, base_hi_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] wr_idx, wr_idx_nx;
  logic       wr_pend, wr_pend_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DMA_IDLE;
      base_hi <= 8'h00;
      idx     <= 8'h00;
      wr_idx  <= 8'h00;
      wr_pend <= 1'b0;
    end else begin
      state   <= state_nx;
      base_hi <= base_hi_nx;
      idx     <= idx_nx;
      wr_idx  <= wr_idx_nx;
      wr_pend <= wr_pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    base_hi_nx = base_hi;
    idx_nx     = idx;
    wr_idx_nx  = wr_idx;
    wr_pend_nx = 1'b0;
    case (state)
      DMA_ISSUE: begin
        // data for this address arrives next cycle, so its OAM write is queued one behind
        wr_pend_nx = 1'b1;
        wr_idx_nx  = idx;
        if (idx == LAST_IDX) state_nx = DMA_DRAIN;
        else                 idx_nx   = idx + 8'd1;
      end
      DMA_DRAIN: state_nx = DMA_IDLE;
      default: ;
    endcase
    // a restart discards whatever the old transfer still had queued
    if (start) begin
      state_nx   = DMA_ISSUE;
      base_hi_nx = src_hi;
      idx_nx     = 8'h00;
      wr_pend_nx = 1'b0;
    end
  end

  assign dma_rd    = (state == DMA_ISSUE);
  assign dma_addr  = {base_hi, 8'h00} + {8'h00, idx};
  assign oam_we    = wr_pend;
  assign oam_addr  = wr_idx;
  assign oam_wdata = dma_data;
  assign active    = (state != DMA_IDLE);

endmodule

// File: rtl/gb_video_mem.sv
// rtl/gb_video_mem.sv - VRAM/OAM with PPU fetch port, mode-gated CPU access and OAM DMA
module gb_video_mem #(
  parameter int VRAM_AW   = 13,
  parameter int OAM_BYTES = 160,
  parameter int DMA_LEN   = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA,
  output logic        DMA_ACTIVE
);
  import gb_video_pkg::*;

  localparam logic [15:0] OAM_LIMIT = OAM_BASE_ADDR + 16'(OAM_BYTES);

  logic [7:0] vram [0:(1 << VRAM_AW) - 1];
  logic [7:0] oam  [0:OAM_BYTES - 1];

  PPU_STATES_t mode;
  logic        cpu_vram_hit, cpu_oam_hit, ppu_vram_hit, ppu_oam_hit;
  logic        vram_ok, oam_ok, cpu_vram_we, cpu_oam_we, dma_start;
  logic        dma_we, oam_b_we;
  logic [7:0]  dma_waddr, dma_wdata, oam_b_addr, oam_b_wdata;

  assign mode         = PPU_STATES_t'(PPU_MODE);
  assign cpu_vram_hit = (ADDR >= TILE_BASE) && (ADDR <= VRAM_END_ADDR);
  assign cpu_oam_hit  = (ADDR >= OAM_BASE_ADDR) && (ADDR < OAM_LIMIT);
  assign ppu_vram_hit = (PPU_ADDR >= TILE_BASE) && (PPU_ADDR <= VRAM_END_ADDR);
  assign ppu_oam_hit  = (PPU_ADDR >= OAM_BASE_ADDR) && (PPU_ADDR < OAM_LIMIT);

  assign vram_ok     = (mode != DRAW);
  assign oam_ok      = ((mode == H_BLANK) || (mode == V_BLANK)) && !DMA_ACTIVE;
  assign cpu_vram_we = WR && cpu_vram_hit && vram_ok;
  assign cpu_oam_we  = WR && cpu_oam_hit && oam_ok;
  assign dma_start   = WR && (ADDR == DMA_REG_ADDR);

  gb_oam_dma #(.DMA_LEN(DMA_LEN)) u_dma (
    .clk       (clk),
    .rst       (rst),
    .start     (dma_start),
    .src_hi    (MMIO_DATA_out),
    .dma_rd    (DMA_RD),
    .dma_addr  (DMA_ADDR),
    .dma_data  (DMA_DATA),
    .oam_we    (dma_we),
    .oam_addr  (dma_waddr),
    .oam_wdata (dma_wdata),
    .active    (DMA_ACTIVE)
  );

  // CPU and DMA share OAM port B; the CPU is locked out whenever DMA can write
  assign oam_b_we    = dma_we || cpu_oam_we;
  assign oam_b_addr  = dma_we ? dma_waddr : ADDR[7:0];
  assign oam_b_wdata = dma_we ? dma_wdata : MMIO_DATA_out;

  always_ff @(posedge clk) begin
    if (cpu_vram_we) vram[ADDR[VRAM_AW-1:0]] <= MMIO_DATA_out;
    if (oam_b_we)    oam[oam_b_addr]         <= oam_b_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MMIO_DATA_in <= 8'hFF;
    end else if (RD) begin
      if (cpu_vram_hit && vram_ok)    MMIO_DATA_in <= vram[ADDR[VRAM_AW-1:0]];
      else if (cpu_oam_hit && oam_ok) MMIO_DATA_in <= oam[ADDR[7:0]];
      else                            MMIO_DATA_in <= 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PPU_DATA_in <= 8'hFF;
    end else if (PPU_RD) begin
      if (ppu_vram_hit)                    PPU_DATA_in <= vram[PPU_ADDR[VRAM_AW-1:0]];
      else if (ppu_oam_hit && !DMA_ACTIVE) PPU_DATA_in <= oam[PPU_ADDR[7:0]];
      else                                 PPU_DATA_in <= 8'hFF;
    end
  end

endmodule
